// File: rtl/imm_pkg.sv
// Shared constants for the decode-stage immediate generator.
// Holds RV base opcodes, the 3-bit format encoding reported on out_fmt,
// and the OP-IMM funct3 values that select shift-amount immediates.
package imm_pkg;

    // Base opcodes (instr[6:0])
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Format codes
    localparam logic [2:0] FMT_R     = 3'd0;
    localparam logic [2:0] FMT_I     = 3'd1;
    localparam logic [2:0] FMT_SHAMT = 3'd2;
    localparam logic [2:0] FMT_S     = 3'd3;
    localparam logic [2:0] FMT_B     = 3'd4;
    localparam logic [2:0] FMT_U     = 3'd5;
    localparam logic [2:0] FMT_J     = 3'd6;
    localparam logic [2:0] FMT_NONE  = 3'd7;

    // OP-IMM funct3 values carrying a shift amount (SLLI, SRLI/SRAI)
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

endpackage

// File: rtl/imm_decode.sv
// Combinational immediate decoder.
// Ports:
//   instr   in  32    raw instruction word
//   imm     out XLEN  sign/zero-extended immediate
//   fmt     out 3     format code (FMT_*)
//   illegal out 1     opcode not recognised
module imm_decode
    import imm_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal
);

    // RV64 shifts use a 6-bit shamt, RV32 a 5-bit one.
    localparam logic [31:0] SHAMT_MASK = (XLEN == 64) ? 32'h0000_003F : 32'h0000_001F;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_OP_IMM: begin
                if (funct3 == F3_SLL || funct3 == F3_SR) begin
                    fmt   = FMT_SHAMT;
                    imm32 = {26'b0, instr[25:20]} & SHAMT_MASK;
                end else begin
                    fmt   = FMT_I;
                    imm32 = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LOAD, OPC_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OPC_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OPC_BRANCH: begin
                fmt   = FMT_B;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                fmt   = FMT_U;
                imm32 = {instr[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt   = FMT_J;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            OPC_OP: begin
                fmt   = FMT_R;
                imm32 = '0;
            end
            default: begin
                fmt     = FMT_NONE;
                illegal = 1'b1;
            end
        endcase
    end

    // imm32 is already sign-extended to bit 31; shamt values have bit 31 clear,
    // so one signed widening covers every format.
    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/imm_gen_pipe.sv
// Pipelined immediate generator: decodes instr, registers the result behind a
// valid/ready handshake with a one-entry skid buffer (2 entries total).
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   flush                 drop both in-flight entries and the current input
//   in_valid/in_ready     input handshake; in_ready is registered (!skid full)
//   in_instr, in_tag      instruction word and sideband tag
//   out_valid/out_ready   output handshake
//   out_imm/out_fmt/out_illegal/out_tag  presented entry
//   illegal_cnt           saturating count of illegal entries transferred out
module imm_gen_pipe
    import imm_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 5,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] illegal_cnt
);

    logic [XLEN-1:0] dec_imm;
    logic [2:0]      dec_fmt;
    logic            dec_illegal;

    imm_decode #(
        .XLEN(XLEN)
    ) u_decode (
        .instr  (in_instr),
        .imm    (dec_imm),
        .fmt    (dec_fmt),
        .illegal(dec_illegal)
    );

    // Output register
    logic             out_valid_q,   out_valid_d;
    logic [XLEN-1:0]  out_imm_q,     out_imm_d;
    logic [2:0]       out_fmt_q,     out_fmt_d;
    logic             out_illegal_q, out_illegal_d;
    logic [TAG_W-1:0] out_tag_q,     out_tag_d;

    // Skid register
    logic             skid_valid_q,   skid_valid_d;
    logic [XLEN-1:0]  skid_imm_q,     skid_imm_d;
    logic [2:0]       skid_fmt_q,     skid_fmt_d;
    logic             skid_illegal_q, skid_illegal_d;
    logic [TAG_W-1:0] skid_tag_q,     skid_tag_d;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic in_fire;
    logic out_fire;
    logic out_load;

    assign in_ready = !skid_valid_q;
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid_q && out_ready;
    assign out_load = !out_valid_q || out_ready;

    always_comb begin
        out_valid_d    = out_valid_q;
        out_imm_d      = out_imm_q;
        out_fmt_d      = out_fmt_q;
        out_illegal_d  = out_illegal_q;
        out_tag_d      = out_tag_q;
        skid_valid_d   = skid_valid_q;
        skid_imm_d     = skid_imm_q;
        skid_fmt_d     = skid_fmt_q;
        skid_illegal_d = skid_illegal_q;
        skid_tag_d     = skid_tag_q;
        cnt_d          = cnt_q;

        if (flush) begin
            // Flush wins over transfers: nothing leaves, nothing is counted.
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end else begin
            if (out_fire && out_illegal_q && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end

            if (out_load) begin
                if (skid_valid_q) begin
                    // in_ready is low whenever the skid is full, so no input
                    // can compete with the drain.
                    out_valid_d   = 1'b1;
                    out_imm_d     = skid_imm_q;
                    out_fmt_d     = skid_fmt_q;
                    out_illegal_d = skid_illegal_q;
                    out_tag_d     = skid_tag_q;
                    skid_valid_d  = 1'b0;
                end else begin
                    out_valid_d = in_fire;
                    if (in_fire) begin
                        out_imm_d     = dec_imm;
                        out_fmt_d     = dec_fmt;
                        out_illegal_d = dec_illegal;
                        out_tag_d     = in_tag;
                    end
                end
            end else if (in_fire) begin
                // Output is stalled; park the new entry.
                skid_valid_d   = 1'b1;
                skid_imm_d     = dec_imm;
                skid_fmt_d     = dec_fmt;
                skid_illegal_d = dec_illegal;
                skid_tag_d     = in_tag;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q    <= 1'b0;
            out_imm_q      <= '0;
            out_fmt_q      <= '0;
            out_illegal_q  <= 1'b0;
            out_tag_q      <= '0;
            skid_valid_q   <= 1'b0;
            skid_imm_q     <= '0;
            skid_fmt_q     <= '0;
            skid_illegal_q <= 1'b0;
            skid_tag_q     <= '0;
            cnt_q          <= '0;
        end else begin
            out_valid_q    <= out_valid_d;
            out_imm_q      <= out_imm_d;
            out_fmt_q      <= out_fmt_d;
            out_illegal_q  <= out_illegal_d;
            out_tag_q      <= out_tag_d;
            skid_valid_q   <= skid_valid_d;
            skid_imm_q     <= skid_imm_d;
            skid_fmt_q     <= skid_fmt_d;
            skid_illegal_q <= skid_illegal_d;
            skid_tag_q     <= skid_tag_d;
            cnt_q          <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_imm     = out_imm_q;
    assign out_fmt     = out_fmt_q;
    assign out_illegal = out_illegal_q;
    assign out_tag     = out_tag_q;
    assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [4:0]  in_tag;
    logic        out_ready;

    // XLEN=32 instance
    logic        in_ready_a, out_valid_a, out_illegal_a;
    logic [31:0] out_imm_a;
    logic [2:0]  out_fmt_a;
    logic [4:0]  out_tag_a;
    logic [15:0] cnt_a;

    // XLEN=64 instance
    logic        in_ready_b, out_valid_b, out_illegal_b;
    logic [63:0] out_imm_b;
    logic [2:0]  out_fmt_b;
    logic [4:0]  out_tag_b;
    logic [15:0] cnt_b;

    // CNT_W=2 instance
    logic        in_ready_c, out_valid_c, out_illegal_c;
    logic [31:0] out_imm_c;
    logic [2:0]  out_fmt_c;
    logic [4:0]  out_tag_c;
    logic [1:0]  cnt_c;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(16)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_a), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_imm(out_imm_a),
        .out_fmt(out_fmt_a), .out_illegal(out_illegal_a), .out_tag(out_tag_a),
        .illegal_cnt(cnt_a)
    );

    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .CNT_W(16)) dut64 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_b), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_imm(out_imm_b),
        .out_fmt(out_fmt_b), .out_illegal(out_illegal_b), .out_tag(out_tag_b),
        .illegal_cnt(cnt_b)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready_c), .in_instr(in_instr), .in_tag(in_tag),
        .out_valid(out_valid_c), .out_ready(out_ready), .out_imm(out_imm_c),
        .out_fmt(out_fmt_c), .out_illegal(out_illegal_c), .out_tag(out_tag_c),
        .illegal_cnt(cnt_c)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] imm32;
        logic [63:0] imm64;
        logic [2:0]  fmt;
        logic        ill;
    } vec_t;

    localparam int NVEC = 16;
    vec_t vecs [NVEC];

    int n_vec  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic present(input logic [31:0] instr, input logic [4:0] tag);
        in_valid = 1'b1;
        in_instr = instr;
        in_tag   = tag;
    endtask

    initial begin
        int exp_cnt;

        vecs[0]  = '{32'hFFF00093, 64'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd4, 1'b0};
        vecs[2]  = '{32'h123450B7, 64'h1234_5000, 64'h0000_0000_1234_5000, 3'd5, 1'b0};
        vecs[3]  = '{32'h0080006F, 64'h0000_0008, 64'h0000_0000_0000_0008, 3'd6, 1'b0};
        vecs[4]  = '{32'h4030D093, 64'h0000_0003, 64'h0000_0000_0000_0003, 3'd2, 1'b0};
        vecs[5]  = '{32'hFE112E23, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd3, 1'b0};
        vecs[6]  = '{32'h00B50533, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd0, 1'b0};
        vecs[7]  = '{32'hFFFFF017, 64'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 3'd5, 1'b0};
        vecs[8]  = '{32'h7FF42083, 64'h0000_07FF, 64'h0000_0000_0000_07FF, 3'd1, 1'b0};
        vecs[9]  = '{32'h800080E7, 64'hFFFF_F800, 64'hFFFF_FFFF_FFFF_F800, 3'd1, 1'b0};
        vecs[10] = '{32'h0000007F, 64'h0000_0000, 64'h0000_0000_0000_0000, 3'd7, 1'b1};
        vecs[11] = '{32'hFFF09093, 64'h0000_001F, 64'h0000_0000_0000_003F, 3'd2, 1'b0};
        vecs[12] = '{32'h800000B7, 64'h8000_0000, 64'hFFFF_FFFF_8000_0000, 3'd5, 1'b0};
        vecs[13] = '{32'h0210D093, 64'h0000_0001, 64'h0000_0000_0000_0021, 3'd2, 1'b0};
        vecs[14] = '{32'h80000063, 64'hFFFF_F000, 64'hFFFF_FFFF_FFFF_F000, 3'd4, 1'b0};
        vecs[15] = '{32'hFFDFF06F, 64'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 3'd6, 1'b0};

        // Reset state
        do_reset();
        check("rst_out_valid", 64'(out_valid_a), 64'd0);
        check("rst_in_ready", 64'(in_ready_a), 64'd1);
        check("rst_out_imm", 64'(out_imm_a), 64'd0);
        check("rst_out_fmt", 64'(out_fmt_a), 64'd0);
        check("rst_cnt", 64'(cnt_a), 64'd0);

        // Unstalled stream: one per cycle, 1-cycle latency
        out_ready = 1'b1;
        exp_cnt   = 0;
        for (int i = 0; i < NVEC; i++) begin
            present(vecs[i].instr, 5'(i));
            tick();
            check("strm_valid", 64'(out_valid_a), 64'd1);
            check("strm_imm32", 64'(out_imm_a), vecs[i].imm32);
            check("strm_imm64", out_imm_b, vecs[i].imm64);
            check("strm_fmt", 64'(out_fmt_a), 64'(vecs[i].fmt));
            check("strm_fmt64", 64'(out_fmt_b), 64'(vecs[i].fmt));
            check("strm_ill", 64'(out_illegal_a), 64'(vecs[i].ill));
            check("strm_tag", 64'(out_tag_a), 64'(i));
            check("strm_in_ready", 64'(in_ready_a), 64'd1);
            check("strm_cnt", 64'(cnt_a), 64'(exp_cnt));
            if (vecs[i].ill) exp_cnt++;
        end
        in_valid = 1'b0;
        tick();
        check("strm_drain_valid", 64'(out_valid_a), 64'd0);
        check("strm_drain_cnt", 64'(cnt_a), 64'(exp_cnt));

        // Backpressure: 3 offered with out_ready=0, 2 accepted
        do_reset();
        present(32'hFFF00093, 5'd1);
        tick();
        check("bp_a_valid", 64'(out_valid_a), 64'd1);
        check("bp_a_ready", 64'(in_ready_a), 64'd1);
        present(32'h123450B7, 5'd2);
        tick();
        check("bp_b_ready", 64'(in_ready_a), 64'd0);
        check("bp_hold_tag", 64'(out_tag_a), 64'd1);
        present(32'h0080006F, 5'd3);
        tick();
        check("bp_c_ready", 64'(in_ready_a), 64'd0);
        check("bp_hold_tag2", 64'(out_tag_a), 64'd1);
        check("bp_hold_imm", 64'(out_imm_a), 64'hFFFF_FFFF);
        out_ready = 1'b1;
        tick();
        check("bp_out_b_tag", 64'(out_tag_a), 64'd2);
        check("bp_out_b_imm", 64'(out_imm_a), 64'h1234_5000);
        check("bp_out_b_ready", 64'(in_ready_a), 64'd1);
        tick();
        in_valid = 1'b0;
        check("bp_out_c_valid", 64'(out_valid_a), 64'd1);
        check("bp_out_c_tag", 64'(out_tag_a), 64'd3);
        check("bp_out_c_imm", 64'(out_imm_a), 64'h0000_0008);
        tick();
        check("bp_empty", 64'(out_valid_a), 64'd0);

        // Illegal then legal
        do_reset();
        out_ready = 1'b1;
        present(32'h0000007F, 5'd1);
        tick();
        check("ill_flag", 64'(out_illegal_a), 64'd1);
        check("ill_fmt", 64'(out_fmt_a), 64'd7);
        check("ill_imm", 64'(out_imm_a), 64'd0);
        check("ill_cnt0", 64'(cnt_a), 64'd0);
        present(32'hFFF00093, 5'd2);
        tick();
        check("ill_legal_flag", 64'(out_illegal_a), 64'd0);
        check("ill_legal_fmt", 64'(out_fmt_a), 64'd1);
        check("ill_cnt1", 64'(cnt_a), 64'd1);
        in_valid = 1'b0;
        tick();
        check("ill_cnt_final", 64'(cnt_a), 64'd1);

        // Flush with both entries full and an input presented
        do_reset();
        present(32'h0000007F, 5'd4);
        tick();
        present(32'h0000007F, 5'd5);
        tick();
        check("fl_full", 64'(in_ready_a), 64'd0);
        present(32'hFFF00093, 5'd6);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_valid", 64'(out_valid_a), 64'd0);
        check("fl_ready", 64'(in_ready_a), 64'd1);
        out_ready = 1'b1;
        tick();
        check("fl_nothing", 64'(out_valid_a), 64'd0);
        check("fl_cnt", 64'(cnt_a), 64'd0);
        // Flush with room: the presented input is still dropped
        present(32'h123450B7, 5'd7);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_drop_in", 64'(out_valid_a), 64'd0);
        tick();
        check("fl_drop_in2", 64'(out_valid_a), 64'd0);

        // Counter saturation (CNT_W=2)
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            present(32'h0000007F, 5'(i));
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("sat_cnt2", 64'(cnt_c), 64'd3);
        check("sat_cnt16", 64'(cnt_a), 64'd5);

        // Reset mid-stream with both entries occupied
        out_ready = 1'b0;
        present(32'hFFF00093, 5'd7);
        tick();
        present(32'h123450B7, 5'd8);
        tick();
        check("mrst_full", 64'(in_ready_a), 64'd0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        tick();
        check("mrst_valid", 64'(out_valid_a), 64'd0);
        check("mrst_imm", 64'(out_imm_a), 64'd0);
        check("mrst_imm64", out_imm_b, 64'd0);
        check("mrst_fmt", 64'(out_fmt_a), 64'd0);
        check("mrst_tag", 64'(out_tag_a), 64'd0);
        check("mrst_ill", 64'(out_illegal_a), 64'd0);
        check("mrst_cnt", 64'(cnt_a), 64'd0);
        check("mrst_cnt_sat", 64'(cnt_c), 64'd0);
        check("mrst_ready", 64'(in_ready_a), 64'd1);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("mrst_no_emit", 64'(out_valid_a), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
Pipelined, parametrised immediate generator for the decode stage. It decodes the instruction format directly from opcode/funct3, with no one-hot instruction flags from upstream. It builds the sign- or zero-extended immediate at XLEN width and returns it with a format code and an illegal-opcode flag. Output is registered behind a valid/ready handshake with a skid buffer, so the fetch and execute stages can stall independently. A flush input is provided for branch redirects.

Parameters:
XLEN, 32, datapath width; legal values 32 or 64. Sets sign-extension width and shamt width (5 or 6 bits).
TAG_W, 5, width of the sideband tag (e.g. ROB/PC index) carried alongside each instruction.
CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  reset, synchronous, active-low.
flush  in  1  drop all in-flight entries; synchronous.
in_valid  in  1  instruction present.
in_ready  out  1  block can accept this cycle.
in_instr  in  32  raw instruction word.
in_tag  in  TAG_W  sideband tag.
out_valid  out  1  immediate available.
out_ready  in  1  consumer accepts this cycle.
out_imm  out  XLEN  generated immediate.
out_fmt  out  3  format: 0 R, 1 I, 2 SHAMT, 3 S, 4 B, 5 U, 6 J, 7 NONE.
out_illegal  out  1  opcode not recognised.
out_tag  out  TAG_W  tag of the presented entry.
illegal_cnt  out  CNT_W  count of illegal instructions that left the block.

Behaviour:
- Reset (rst_n=0 at a clk edge): out_valid=0, skid empty, in_ready=1 on the following cycle. out_imm, out_fmt, out_tag and out_illegal clear to 0. illegal_cnt=0.
- Decode (combinational, on in_instr; opcode = bits 6:0):
  - 0010011 with funct3=001 or 101 -> SHAMT. imm = zero-extended instr[24:20] when XLEN=32, instr[25:20] when XLEN=64.
  - Other 0010011, plus 0000011 and 1100111 -> I. imm = sext(instr[31:20]).
  - 0100011 -> S. imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 -> B. imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 and 0010111 -> U. imm = sext({instr[31:12], 12'b0}); this matters for XLEN=64.
  - 1101111 -> J. imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 -> R. imm = 0.
  - Anything else -> NONE. imm = 0, illegal = 1.
  - Sign extension is always from instr[31], except SHAMT.
- Handshake:
  - Transfer on the input side when in_valid & in_ready; on the output side when out_valid & out_ready.
  - in_ready = !skid_valid, driven from a register with no combinational path from out_ready.
  - Output register loads when (!out_valid | out_ready). It takes the skid entry if one is held, otherwise the decoded input.
  - An input accepted while the output register is held (out_valid & !out_ready) goes to the skid register; in_ready drops next cycle.
  - A full skid drains into the output register on the first cycle with out_ready=1.
  - Latency is 1 cycle, in_valid to out_valid, when unstalled. Throughput is 1 per cycle with out_ready held high.
  - Ordering is strictly FIFO; capacity is 2 entries (output register + skid).
  - The output holds stable while out_valid & !out_ready.
- Flush:
  - Next cycle: out_valid=0, skid empty, in_ready=1.
  - An input presented in the flush cycle is discarded.
  - flush has priority over every other event. rst_n has priority over flush.
- illegal_cnt:
  - Increments by 1 on each output transfer with out_illegal=1.
  - Saturates at all-ones.
  - Not cleared by flush; flushed entries never count.
- Reset mid-operation discards both entries with no output transfer.

Decomposition:
- Shared package imm_pkg holds: opcode constants (OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_STORE, OPC_BRANCH, OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_OP), the format encoding constants FMT_R..FMT_NONE, and the SHAMT funct3 values.
- One combinational sub-module, imm_decode (instr -> imm, fmt, illegal; parametrised on XLEN).
- imm_gen_pipe holds the output register, skid buffer, flush logic and counter.

Test Plan:
- XLEN=32, unstalled stream 0xFFF00093, 0xFE000EE3, 0x123450B7, 0x0080006F, 0x4030D093 -> one per cycle, each 1 cycle later:
  - imm 0xFFFFFFFF fmt I
  - 0xFFFFFFFC B
  - 0x12345000 U
  - 0x00000008 J
  - 0x00000003 SHAMT
- XLEN=64, input 0x800000B7 (LUI) -> out_imm 0xFFFFFFFF80000000, fmt U.
- Backpressure: out_ready=0 while 3 instructions are offered -> 2 accepted, in_ready=0 from the cycle after the 2nd. Raise out_ready -> outputs in order, no loss or duplication, in_ready back to 1.
- Illegal: 0x0000007F then 0xFFF00093 -> first out_illegal=1 fmt NONE imm 0, second legal; illegal_cnt=1 after the transfer.
- Flush with both entries full and in_valid=1 -> next cycle out_valid=0, in_ready=1, nothing emitted, illegal_cnt unchanged.
- Counter saturation with CNT_W=2: 5 illegal transfers -> illegal_cnt stays 3. Assert rst_n=0 mid-stream -> all outputs 0 the next cycle.
